// File: rtl/booth_pkg.sv
// booth_pkg: shared definitions for the Booth result collector.
// Holds the collector state encoding, the byte and product widths, the
// default FIFO depth and a helper that assembles the signed product.
package booth_pkg;

  localparam int BYTE_W        = 8;
  localparam int PROD_W        = 16;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    WAIT_HI = 2'd0,
    WAIT_LO = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // The multiplier emits the product high byte first, low byte second.
  function automatic logic [PROD_W-1:0] assemble(input logic [BYTE_W-1:0] hi,
                                                 input logic [BYTE_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/booth_res_fifo.sv
// booth_res_fifo: small synchronous FIFO for assembled products.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push, push_data  write request and data (dropped when full without pop)
//   pop              read request (ignored when empty)
//   pop_data         head entry, reads zero when empty
//   cnt              occupancy 0..DEPTH
//   full, empty      occupancy flags
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module booth_res_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] cnt,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    cnt_reg;
  logic             do_push;
  logic             do_pop;

  assign empty = (cnt_reg == '0);
  assign full  = (cnt_reg == CW'(DEPTH));

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  // Storage carries no reset; stale entries are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr_reg];
  assign cnt      = cnt_reg;

endmodule

// File: rtl/booth_result_collector.sv
// booth_result_collector: assembles the two product bytes streamed by a
// Booth multiplier into 16-bit signed products and queues them for a
// consumer.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   obus, ob_vld    product byte and its one-cycle strobe (high byte first)
//   stop            multiplier done level; its fall re-arms the collector
//   prod, prod_vld  FIFO head and non-empty flag
//   prod_rdy        consumer accepts prod this cycle
//   cnt             FIFO occupancy
//   ovf             sticky: a product was dropped on a full FIFO
//   perr            sticky: byte strobe or stop seen out of sequence
module booth_result_collector
  import booth_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BYTE_W-1:0]      obus,
  input  logic                   ob_vld,
  input  logic                   stop,
  output logic [PROD_W-1:0]      prod,
  output logic                   prod_vld,
  input  logic                   prod_rdy,
  output logic [$clog2(DEPTH):0] cnt,
  output logic                   ovf,
  output logic                   perr
);

  state_t            state_reg, state_next;
  logic [BYTE_W-1:0] hi_reg, hi_next;
  logic              ovf_reg;
  logic              perr_reg;
  logic              push;
  logic              perr_set;
  logic              pop;
  logic              full;
  logic              empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= WAIT_HI;
      hi_reg    <= '0;
      ovf_reg   <= 1'b0;
      perr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      hi_reg    <= hi_next;
      // A push is dropped only when full and nothing leaves this cycle.
      if (push && full && !pop) ovf_reg <= 1'b1;
      if (perr_set)             perr_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    hi_next    = hi_reg;
    push       = 1'b0;
    perr_set   = 1'b0;
    case (state_reg)
      WAIT_HI: begin
        if (ob_vld) begin
          hi_next    = obus;
          state_next = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (ob_vld) begin
          push       = 1'b1;
          state_next = HOLD;
        end else if (!stop) begin
          // Multiplier restarted before the low byte arrived.
          hi_next    = '0;
          perr_set   = 1'b1;
          state_next = WAIT_HI;
        end
      end
      HOLD: begin
        if (ob_vld) perr_set = 1'b1;
        if (!stop)  state_next = WAIT_HI;
      end
      default: state_next = WAIT_HI;
    endcase
  end

  assign pop = prod_rdy & ~empty;

  booth_res_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PROD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (assemble(hi_reg, obus)),
    .pop       (pop),
    .pop_data  (prod),
    .cnt       (cnt),
    .full      (full),
    .empty     (empty)
  );

  assign prod_vld = ~empty;
  assign ovf      = ovf_reg;
  assign perr     = perr_reg;

endmodule

// File: tb/tb_booth_result_collector.sv
module tb_booth_result_collector;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  obus = '0;
  logic        ob_vld = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] prod;
  logic        prod_vld;
  logic        prod_rdy = 1'b0;
  logic [2:0]  cnt;
  logic        ovf;
  logic        perr;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] q[$];
  logic        m_ovf = 1'b0;
  logic        m_perr = 1'b0;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  booth_result_collector #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .obus     (obus),
    .ob_vld   (ob_vld),
    .stop     (stop),
    .prod     (prod),
    .prod_vld (prod_vld),
    .prod_rdy (prod_rdy),
    .cnt      (cnt),
    .ovf      (ovf),
    .perr     (perr)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("cnt", 16'(cnt), 16'(q.size()));
    check("prod_vld", 16'(prod_vld), 16'(q.size() > 0));
    check("prod", prod, (q.size() > 0) ? q[0] : 16'h0000);
    check("ovf", 16'(ovf), 16'(m_ovf));
    check("perr", 16'(perr), 16'(m_perr));
  endtask

  // One clock edge; models pop-then-push and checks all outputs after it.
  task automatic tick(input bit do_push, input logic [15:0] pv);
    bit pop_now;
    pop_now = prod_rdy && (q.size() > 0);
    if (pop_now) check("pop_data", prod, q[0]);
    @(posedge clk);
    #1;
    if (pop_now) begin
      $display("pop  prod=%h", q[0]);
      void'(q.pop_front());
    end
    if (do_push) begin
      if (q.size() < DEPTH) begin
        q.push_back(pv);
        $display("push prod=%h", pv);
      end else begin
        m_ovf = 1'b1;
        $display("drop prod=%h (full)", pv);
      end
    end
    check_outputs();
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    ob_vld = 1'b0;
    obus = '0;
    #2;
    q.delete();
    m_ovf = 1'b0;
    m_perr = 1'b0;
    // Outputs must clear without waiting for a clock edge.
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic byte_hi(input logic [7:0] b);
    stop = 1'b1; ob_vld = 1'b1; obus = b;
    tick(1'b0, 16'h0);
    ob_vld = 1'b0; obus = '0;
  endtask

  task automatic byte_lo(input logic [7:0] b, input logic [15:0] exp);
    stop = 1'b1; ob_vld = 1'b1; obus = b;
    tick(1'b1, exp);
    ob_vld = 1'b0; obus = '0;
  endtask

  task automatic release_stop();
    stop = 1'b0;
    tick(1'b0, 16'h0);
  endtask

  task automatic send_pair(input logic [7:0] hi, input logic [7:0] lo, input logic [15:0] exp);
    byte_hi(hi);
    byte_lo(lo, exp);
    release_stop();
  endtask

  initial begin
    tbl[0] = '{hi: 8'h00, lo: 8'h06, exp: 16'h0006};
    tbl[1] = '{hi: 8'hFF, lo: 8'hFA, exp: 16'hFFFA};
    tbl[2] = '{hi: 8'h7F, lo: 8'hFF, exp: 16'h7FFF};
    tbl[3] = '{hi: 8'h80, lo: 8'h00, exp: 16'h8000};
    tbl[4] = '{hi: 8'h12, lo: 8'h34, exp: 16'h1234};
    tbl[5] = '{hi: 8'hFF, lo: 8'hFF, exp: 16'hFFFF};

    do_reset();

    // Basic products, each drained on the edge after release of stop.
    prod_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_pair(tbl[i].hi, tbl[i].lo, tbl[i].exp);
      tick(1'b0, 16'h0);
    end

    // Five products with no consumer: fifth is dropped, ovf sticks.
    prod_rdy = 1'b0;
    for (int i = 0; i < 5; i++) send_pair(tbl[i].hi, tbl[i].lo, tbl[i].exp);
    check("ovf_after_five", 16'(ovf), 16'h1);
    check("cnt_after_five", 16'(cnt), 16'd4);
    prod_rdy = 1'b1;
    for (int i = 0; i < 5; i++) tick(1'b0, 16'h0);
    // prod_rdy on an empty FIFO must be harmless.
    tick(1'b0, 16'h0);

    // Full FIFO with push and pop on the same edge.
    do_reset();
    prod_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_pair(tbl[i].hi, tbl[i].lo, tbl[i].exp);
    byte_hi(8'hAB);
    prod_rdy = 1'b1;
    byte_lo(8'hCD, 16'hABCD);
    prod_rdy = 1'b0;
    check("cnt_full_pushpop", 16'(cnt), 16'd4);
    check("ovf_full_pushpop", 16'(ovf), 16'h0);
    release_stop();
    prod_rdy = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b0, 16'h0);

    // Extra strobe in HOLD: perr, no push; next pair still collected.
    do_reset();
    prod_rdy = 1'b0;
    byte_hi(8'h01);
    byte_lo(8'h02, 16'h0102);
    ob_vld = 1'b1; obus = 8'h77; stop = 1'b1;
    m_perr = 1'b1;
    tick(1'b0, 16'h0);
    ob_vld = 1'b0; obus = '0;
    release_stop();
    send_pair(8'h03, 8'h04, 16'h0304);
    prod_rdy = 1'b1;
    tick(1'b0, 16'h0);
    tick(1'b0, 16'h0);

    // stop falls in WAIT_LO: hi discarded, perr, next pair intact.
    do_reset();
    byte_hi(8'h5A);
    stop = 1'b0;
    m_perr = 1'b1;
    tick(1'b0, 16'h0);
    send_pair(8'h00, 8'h2A, 16'h002A);
    tick(1'b0, 16'h0);

    // Reset after a lone high byte: next byte is treated as a high byte.
    do_reset();
    byte_hi(8'h55);
    do_reset();
    prod_rdy = 1'b0;
    send_pair(8'h00, 8'h09, 16'h0009);
    check("prod_after_reset", prod, 16'h0009);
    prod_rdy = 1'b1;
    tick(1'b0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/booth_result_collector.md
BOOTH_RESULT_COLLECTOR -- requirements
Module: booth_result_collector

Interface
REQ-001 The block SHALL expose the following ports, clock and reset first:
  - clk  input  1  single system clock; all state updates on rising edge.
  - rst  input  1  asynchronous, active-high reset.
  - obus  input  8  product byte from the upstream Booth multiplier.
  - ob_vld  input  1  one-cycle strobe; obus holds a valid byte.
  - stop  input  1  multiplier done level; high from end of multiplication until the next bgn.
  - prod  output  16  signed product at FIFO head.
  - prod_vld  output  1  FIFO non-empty.
  - prod_rdy  input  1  consumer accepts prod this cycle.
  - cnt  output  3  FIFO occupancy, 0..4.
  - ovf  output  1  sticky: product dropped because the FIFO was full.
  - perr  output  1  sticky: protocol error.
REQ-002 Parameter DEPTH, default 4, is the FIFO entry count and SHALL be a power of two.

Function
REQ-003 The FSM SHALL have three states: WAIT_HI, WAIT_LO and HOLD.
REQ-004 In WAIT_HI with ob_vld=1, the block SHALL latch obus as the high byte (A register) and go to WAIT_LO.
REQ-005 In WAIT_LO with ob_vld=1, the block SHALL form {hi, obus} as a 16-bit two's-complement product, push it to the FIFO and go to HOLD.
REQ-006 In HOLD, the block SHALL return to WAIT_HI on the first cycle with stop=0, re-arming for the next multiplication.
REQ-007 An ob_vld=1 in HOLD SHALL be ignored (no push) and SHALL set perr.
REQ-008 In WAIT_LO, a cycle with stop=0 and ob_vld=0 (multiplier restarted mid-readout) SHALL discard hi, set perr and go to WAIT_HI.
REQ-009 Latency: a low byte strobed at edge N into an empty FIFO SHALL give prod_vld=1 and a valid prod after edge N.
REQ-010 Pop SHALL occur when prod_vld=1 and prod_rdy=1; the head then advances at that edge.
REQ-011 Simultaneous push and pop SHALL both complete, including when the FIFO is full, with cnt unchanged.
REQ-012 A push into a full FIFO without a pop SHALL drop the product, set ovf, and leave FIFO contents unchanged.
REQ-013 Pop on empty cannot occur (prod_vld=0), and prod_rdy SHALL be ignored when empty.
REQ-014 Read and write pointers SHALL wrap modulo DEPTH; cnt SHALL saturate at neither bound, since 0..DEPTH is exact.
REQ-015 prod SHALL read 16'h0000 when the FIFO is empty.
REQ-016 ovf and perr SHALL clear only on reset.

Reset
REQ-017 While rst=1, asynchronously: state=WAIT_HI, hi=0, pointers=0, cnt=0, prod=0, prod_vld=0, ovf=0, perr=0.
REQ-018 Reset asserted mid-operation SHALL discard any partial product and all FIFO contents; the first ob_vld after release is treated as a high byte.

Structure
REQ-019 Package booth_pkg SHALL hold the state encoding, the byte width (8), the product width (16) and the default DEPTH.
REQ-020 The FIFO SHALL be a sub-module booth_res_fifo (push/pop/data/cnt/full/empty).
REQ-021 The FSM, byte assembly and sticky flags SHALL live in booth_result_collector.
REQ-022 The target size is roughly 120-250 lines of RTL in total.

Verification
REQ-023 Multiply 2*3: bytes 0x00 then 0x06, then stop falls → prod=0x0006, prod_vld=1 one edge after the low byte, cnt=1.
REQ-024 Multiply -2*3: bytes 0xFF then 0xFA → prod=0xFFFA (-6); pop with prod_rdy=1 → cnt=0, prod_vld=0, prod=0x0000.
REQ-025 Five products with prod_rdy=0 → cnt=4, ovf=1 after the fifth; pop order returns the first four unchanged.
REQ-026 FIFO full with push and pop in the same cycle → cnt stays 4, no ovf, the new product becomes the tail.
REQ-027 Extra ob_vld in HOLD, or stop falling in WAIT_LO → perr=1, no push; the next valid pair is still collected correctly.
REQ-028 rst pulse after the high byte only → all outputs 0; the following pair 0x00,0x09 → prod=0x0009.
